// File: rtl/tx_byte_sched.sv
// Splits a capture word into byte groups, drops groups disabled by the SUMP flags and paces
// the remaining bytes to a UART transmitter through its ready handshake.
module tx_byte_sched #(
  parameter int unsigned GRPS = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              clr_i,
  input  logic [GRPS-1:0]   flgs_i,
  input  logic              word_stb_i,
  input  logic [8*GRPS-1:0] word_i,
  output logic              word_rdy_o,
  input  logic              uart_rdy_i,
  output logic              byte_stb_o,
  output logic [7:0]        byte_o,
  output logic              busy_o
);

  localparam int unsigned IW = (GRPS > 1) ? $clog2(GRPS) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [8*GRPS-1:0]   word_q, word_d;
  logic [GRPS-1:0]     mask_q, mask_d;
  logic                stb_q, stb_d;
  logic [7:0]          byte_q, byte_d;

  logic                advance;
  logic                last;
  logic [IW-1:0]       nidx;

  // The strobe register is loaded on the edge that enters the strobe cycle, so the send
  // decision for a group is taken on the edge that selects it (accept, skip or end of gap).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    word_d  = word_q;
    mask_d  = mask_q;
    stb_d   = 1'b0;
    byte_d  = byte_q;
    advance = 1'b0;
    last    = (idx_q == IW'(GRPS - 1));
    nidx    = idx_q + IW'(1);

    unique case (state_q)
      StIdle: begin
        if (word_stb_i) begin
          word_d  = word_i;
          mask_d  = flgs_i;
          idx_d   = '0;
          state_d = StSend;
          if (!flgs_i[0] && uart_rdy_i) begin
            stb_d  = 1'b1;
            byte_d = word_i[7:0];
          end
        end
      end
      StSend: begin
        if (stb_q) begin
          state_d = StGap;
          gap_d   = '0;
        end else if (mask_q[idx_q]) begin
          advance = 1'b1;
        end else if (uart_rdy_i) begin
          stb_d  = 1'b1;
          byte_d = word_q[{idx_q, 3'b000} +: 8];
        end
      end
      StGap: begin
        if (gap_q == GW'(GAP - 1)) begin
          advance = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (last) begin
        state_d = StIdle;
        idx_d   = '0;
      end else begin
        state_d = StSend;
        idx_d   = nidx;
        if (!mask_q[nidx] && uart_rdy_i) begin
          stb_d  = 1'b1;
          byte_d = word_q[{nidx, 3'b000} +: 8];
        end
      end
    end

    if (clr_i) begin
      state_d = StIdle;
      idx_d   = '0;
      gap_d   = '0;
      stb_d   = 1'b0;
      byte_d  = byte_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      idx_q   <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      mask_q  <= '0;
      stb_q   <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      stb_q   <= stb_d;
      byte_q  <= byte_d;
    end
  end

  assign word_rdy_o = (state_q == StIdle) && !clr_i;
  assign byte_stb_o = stb_q && !clr_i;
  assign byte_o     = byte_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_tx_byte_sched.sv
// Randomized and directed bench for tx_byte_sched, checked every cycle against a queue-based
// model of the byte schedule plus literal expectations for the directed words.
module tb_tx_byte_sched;

  localparam int GRPS = 4;
  localparam int GAP  = 1;

  logic            clk_i = 1'b0;
  logic            rst_in = 1'b0;
  logic            clr_i = 1'b0;
  logic [GRPS-1:0] flgs_i = '0;
  logic            word_stb_i = 1'b0;
  logic [31:0]     word_i = '0;
  logic            uart_rdy_i = 1'b0;
  logic            word_rdy_o;
  logic            byte_stb_o;
  logic [7:0]      byte_o;
  logic            busy_o;

  tx_byte_sched #(.GRPS(GRPS), .GAP(GAP)) dut (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .clr_i      (clr_i),
    .flgs_i     (flgs_i),
    .word_stb_i (word_stb_i),
    .word_i     (word_i),
    .word_rdy_o (word_rdy_o),
    .uart_rdy_i (uart_rdy_i),
    .byte_stb_o (byte_stb_o),
    .byte_o     (byte_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Logs filled by the monitor from DUT outputs.
  logic [7:0] byte_log[$];
  int         stb_cyc[$];
  logic       rdy_at_stb[$];
  int         acc_cyc[$];
  int         busy_cnt = 0;
  int         rdylow_cnt = 0;

  // Model: remaining groups of the word in flight, front item is the current group.
  logic [7:0] q_byte[$];
  bit         q_skip[$];
  bit         m_busy = 1'b0;
  bit         m_stb = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    q_byte.delete();
    q_skip.delete();
    m_busy = 1'b0;
    m_stb  = 1'b0;
    m_byte = 8'h00;
    m_gap  = 0;
  endtask

  task automatic m_enter();
    if (!q_skip[0] && uart_rdy_i) begin
      m_stb  = 1'b1;
      m_byte = q_byte[0];
    end
  endtask

  task automatic m_next();
    void'(q_byte.pop_front());
    void'(q_skip.pop_front());
    if (q_byte.size() == 0) m_busy = 1'b0;
    else m_enter();
  endtask

  task automatic m_step();
    if (!rst_in) begin
      m_reset();
    end else if (clr_i) begin
      q_byte.delete();
      q_skip.delete();
      m_busy = 1'b0;
      m_stb  = 1'b0;
      m_gap  = 0;
    end else if (!m_busy) begin
      if (word_stb_i) begin
        for (int g = 0; g < GRPS; g++) begin
          q_byte.push_back(word_i[8*g +: 8]);
          q_skip.push_back(flgs_i[g]);
        end
        m_busy = 1'b1;
        m_enter();
      end
    end else if (m_stb) begin
      m_stb = 1'b0;
      m_gap = GAP;
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) m_next();
    end else if (q_skip[0]) begin
      m_next();
    end else if (uart_rdy_i) begin
      m_stb  = 1'b1;
      m_byte = q_byte[0];
    end
  endtask

  task automatic m_compare();
    if (!rst_in) m_reset();
    chk("word_rdy_o", {31'd0, word_rdy_o}, {31'd0, !m_busy && !clr_i});
    chk("byte_stb_o", {31'd0, byte_stb_o}, {31'd0, m_stb && !clr_i});
    chk("byte_o", {24'd0, byte_o}, {24'd0, m_byte});
    chk("busy_o", {31'd0, busy_o}, {31'd0, m_busy});
    if (rst_in) begin
      if (byte_stb_o) begin
        byte_log.push_back(byte_o);
        stb_cyc.push_back(cyc);
        rdy_at_stb.push_back(uart_rdy_i);
      end
      if (word_rdy_o && word_stb_i) acc_cyc.push_back(cyc);
      if (busy_o) busy_cnt++;
      if (!word_rdy_o) rdylow_cnt++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      m_compare();
      @(posedge clk_i);
      m_step();
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    byte_log.delete();
    stb_cyc.delete();
    rdy_at_stb.delete();
    acc_cyc.delete();
    busy_cnt = 0;
    rdylow_cnt = 0;
  endtask

  task automatic send(input logic [31:0] w, input logic [3:0] f);
    bit ok = 1'b0;
    word_stb_i = 1'b1;
    word_i     = w;
    flgs_i     = f;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_i);
      if (word_rdy_o) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    word_stb_i = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      at_neg();
      if (byte_log.size() >= n) ok = 1'b1;
    end
    if (!ok) chk("strobe_timeout", byte_log.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (!busy_o) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_word_rdy"}, {31'd0, word_rdy_o}, 32'd1);
    chk({tag, "_byte_stb"}, {31'd0, byte_stb_o}, 32'd0);
    chk({tag, "_byte_o"}, {24'd0, byte_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  logic [7:0] exp4[4];

  initial begin
    repeat (3) tick();
    at_neg();
    chk_reset_outputs("reset");
    tick();
    rst_in = 1'b1;
    tick();

    // All groups enabled, ready held high.
    clear_logs();
    uart_rdy_i = 1'b1;
    send(32'hDDCCBBAA, 4'b0000);
    repeat (12) tick();
    exp4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    chk("t1_count", byte_log.size(), 4);
    chk("t1_accepts", acc_cyc.size(), 1);
    if (byte_log.size() == 4 && acc_cyc.size() == 1) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_byte", {24'd0, byte_log[i]}, {24'd0, exp4[i]});
        chk("t1_offset", stb_cyc[i] - acc_cyc[0], 2 * i + 1);
      end
    end
    chk("t1_busy_cycles", busy_cnt, 8);
    chk("t1_rdy_low_cycles", rdylow_cnt, 8);

    // Groups 0 and 2 disabled; mask changes mid-word must be ignored.
    clear_logs();
    send(32'h44332211, 4'b0101);
    flgs_i = 4'b0000;
    repeat (12) tick();
    chk("t2_count", byte_log.size(), 2);
    if (byte_log.size() == 2) begin
      chk("t2_byte0", {24'd0, byte_log[0]}, 32'h22);
      chk("t2_byte1", {24'd0, byte_log[1]}, 32'h44);
    end

    // Everything disabled.
    clear_logs();
    send(32'h12345678, 4'b1111);
    repeat (8) tick();
    chk("t3_count", byte_log.size(), 0);
    chk("t3_busy_cycles", busy_cnt, 4);

    // Ready low for 10 cycles ahead of every byte.
    clear_logs();
    uart_rdy_i = 1'b0;
    send(32'h0F0E0D0C, 4'b0000);
    for (int b = 0; b < 4; b++) begin
      repeat (10) tick();
      chk("t4_no_early_strobe", byte_log.size(), b);
      uart_rdy_i = 1'b1;
      wait_log(b + 1, 20);
      tick();
      uart_rdy_i = 1'b0;
    end
    wait_idle(20);
    exp4 = '{8'h0C, 8'h0D, 8'h0E, 8'h0F};
    chk("t4_count", byte_log.size(), 4);
    if (byte_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t4_byte", {24'd0, byte_log[i]}, {24'd0, exp4[i]});
        chk("t4_rdy_at_strobe", {31'd0, rdy_at_stb[i]}, 32'd1);
      end
    end

    // Back-to-back words with the word strobe held high.
    clear_logs();
    uart_rdy_i = 1'b1;
    send(32'h87654321, 4'b0000);
    word_stb_i = 1'b1;
    word_i = 32'h0FEDCBA9;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk_i);
        if (word_rdy_o) ok = 1'b1;
      end
      if (!ok) chk("t5_accept_timeout", 32'd0, 32'd1);
    end
    tick();
    word_stb_i = 1'b0;
    wait_idle(30);
    chk("t5_accepts", acc_cyc.size(), 2);
    chk("t5_count", byte_log.size(), 8);
    if (byte_log.size() == 8) begin
      chk("t5_word0", {byte_log[3], byte_log[2], byte_log[1], byte_log[0]}, 32'h87654321);
      chk("t5_word1", {byte_log[7], byte_log[6], byte_log[5], byte_log[4]}, 32'h0FEDCBA9);
    end

    // Abort after the second byte, then reset in the middle of the next word.
    clear_logs();
    send(32'hA4A3A2A1, 4'b0000);
    wait_log(2, 20);
    tick();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    at_neg();
    chk("t6_idle_after_clr", {31'd0, busy_o}, 32'd0);
    repeat (10) tick();
    chk("t6_count", byte_log.size(), 2);
    if (byte_log.size() == 2) begin
      chk("t6_byte0", {24'd0, byte_log[0]}, 32'hA1);
      chk("t6_byte1", {24'd0, byte_log[1]}, 32'hA2);
    end
    send(32'hB4B3B2B1, 4'b0000);
    repeat (2) tick();
    rst_in = 1'b0;
    at_neg();
    chk_reset_outputs("midreset");
    repeat (2) tick();
    rst_in = 1'b1;
    clear_logs();
    repeat (12) tick();
    chk("t6_no_stray_strobe", byte_log.size(), 0);
    at_neg();
    chk_reset_outputs("after_reset");

    // Random traffic, checked cycle by cycle against the model.
    tick();
    for (int i = 0; i < 500; i++) begin
      word_stb_i = 1'($urandom_range(0, 1));
      word_i     = $urandom;
      flgs_i     = 4'($urandom_range(0, 15));
      uart_rdy_i = ($urandom_range(0, 3) != 0);
      clr_i      = ($urandom_range(0, 39) == 0);
      tick();
    end
    clr_i = 1'b0;
    word_stb_i = 1'b0;
    uart_rdy_i = 1'b1;
    wait_idle(100);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
